aes_link_master: RTL

Platform-side master for the AES chip's handshaked parallel link, generalised in bus width, block width, pacing and timeout. It accepts one request (key, text, expected result, mode), serialises key then text onto the chip's `BUS_W`-bit input bus with a toggle strobe, collects the chip's result beats, and compares them with the expected value. It keeps saturating total/correct counters. It replaces fixed 8-bit pacing logic in the verify platform and sits between the platform's vector source and the chip pins.

---
 rtl/aes_link_pkg.sv | 24 ++
 rtl/aes_link_pacer.sv | 36 +++
 rtl/aes_link_master.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/aes_link_pkg.sv
// Shared types and sizing helpers for the AES chip link master.
package aes_link_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_RX,
    DONE
  } state_t;

  function automatic int tx_beats(input int blk_w, input int bus_w);
    return 2 * blk_w / bus_w;
  endfunction

  function automatic int rx_beats(input int blk_w, input int bus_w);
    return blk_w / bus_w;
  endfunction

  // Width needed to hold values 0..n inclusive.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/aes_link_pacer.sv
// Beat pacer: tick every DIV clocks after restart, half DIV/2 clocks after each tick.
module aes_link_pacer
  import aes_link_pkg::*;
#(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick,
  output logic half
);

  localparam int W = cnt_w(DIV - 1);

  logic [W-1:0] cnt;
  logic         armed;

  // half only fires once a tick has opened a beat
  assign tick = !restart && (cnt == W'(DIV - 1));
  assign half = !restart && armed && (cnt == W'(DIV / 2 - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (restart) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else begin
      cnt <= (cnt == W'(DIV - 1)) ? '0 : cnt + 1'b1;
      if (tick) armed <= 1'b1;
    end
  end

endmodule

// File: rtl/aes_link_master.sv
// Platform master for the AES chip link: serialise key/text, collect result beats,
// compare against the expected block and keep saturating pass/total counters.
module aes_link_master
  import aes_link_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int TX_FREQ  = 50_000,
  parameter int BUS_W    = 8,
  parameter int BLK_W    = 128,
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 1_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [BLK_W-1:0] req_key,
  input  logic [BLK_W-1:0] req_text,
  input  logic [BLK_W-1:0] req_exp,
  input  logic             req_enc,
  output logic             enc,
  output logic [BUS_W-1:0] tx_data,
  output logic             tx_shake,
  input  logic [BUS_W-1:0] rx_data,
  input  logic             rx_shake,
  output logic             res_valid,
  output logic [BLK_W-1:0] res_data,
  output logic             res_match,
  output logic             res_timeout,
  output logic [CNT_W-1:0] total,
  output logic [CNT_W-1:0] correct
);

  localparam int DIV   = CLK_FREQ / TX_FREQ;
  localparam int TXB   = tx_beats(BLK_W, BUS_W);
  localparam int RXB   = rx_beats(BLK_W, BUS_W);
  localparam int TXC_W = cnt_w(TXB);
  localparam int RXC_W = cnt_w(RXB);
  localparam int TO_W  = cnt_w(TIMEOUT);

  state_t             state, state_nx;
  logic               accept, tick, half;
  logic [2*BLK_W-1:0] tx_sr;
  logic [BLK_W-1:0]   exp_q;
  logic [TXC_W-1:0]   tx_cnt;
  logic [RXC_W-1:0]   rx_cnt;
  logic [TO_W-1:0]    to_cnt;
  logic               timed_out;
  logic               shake_s1, shake_s2, shake_s3;
  logic [BUS_W-1:0]   data_s1, data_s2;
  logic               beat_rx, last_tx, last_rx, to_hit;

  assign accept    = req_valid && req_ready;
  assign req_ready = (state == IDLE);
  assign beat_rx   = (state == WAIT_RX) && (shake_s2 ^ shake_s3);
  assign last_tx   = (state == SEND) && half && (tx_cnt == TXC_W'(TXB - 1));
  assign last_rx   = beat_rx && (rx_cnt == RXC_W'(RXB - 1));
  // a strobe edge in the expiry cycle takes priority over the timeout
  assign to_hit    = (state == WAIT_RX) && !beat_rx && (to_cnt == TO_W'(TIMEOUT - 1));

  assign res_valid   = (state == DONE);
  assign res_timeout = (state == DONE) && timed_out;
  assign res_match   = (state == DONE) && !timed_out && (res_data == exp_q);

  aes_link_pacer #(.DIV(DIV)) u_pacer (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(accept),
    .tick   (tick),
    .half   (half)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = SEND;
      SEND:    if (last_tx) state_nx = WAIT_RX;
      WAIT_RX: if (last_rx || to_hit) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // request payload and received-data synchroniser carry no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      tx_sr <= {req_key, req_text};
      exp_q <= req_exp;
    end else if (state == SEND && tick) begin
      tx_sr <= tx_sr << BUS_W;
    end
    data_s1 <= rx_data;
    data_s2 <= data_s1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt    <= '0;
      rx_cnt    <= '0;
      to_cnt    <= '0;
      tx_data   <= '0;
      tx_shake  <= 1'b0;
      enc       <= 1'b1;
      res_data  <= '0;
      timed_out <= 1'b0;
      total     <= '0;
      correct   <= '0;
      shake_s1  <= 1'b0;
      shake_s2  <= 1'b0;
      shake_s3  <= 1'b0;
    end else begin
      {shake_s3, shake_s2, shake_s1} <= {shake_s2, shake_s1, rx_shake};
      case (state)
        IDLE: if (accept) begin
          enc       <= req_enc;
          tx_cnt    <= '0;
          res_data  <= '0;
          timed_out <= 1'b0;
        end
        SEND: begin
          if (tick) tx_data <= tx_sr[2*BLK_W-1 -: BUS_W];
          if (half) begin
            tx_shake <= ~tx_shake;
            tx_cnt   <= tx_cnt + 1'b1;
          end
          if (last_tx) begin
            rx_cnt <= '0;
            to_cnt <= '0;
          end
        end
        WAIT_RX: begin
          if (beat_rx) begin
            res_data[BLK_W-1-int'(rx_cnt)*BUS_W -: BUS_W] <= data_s2;
            rx_cnt <= rx_cnt + 1'b1;
            to_cnt <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
            if (to_hit) timed_out <= 1'b1;
          end
        end
        DONE: begin
          if (total != '1) total <= total + 1'b1;
          if (res_match && correct != '1) correct <= correct + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
